// File: rtl/lna_tr_sequencer_pkg.sv
// Shared state encoding, default timing and output decode for the LNA T/R sequencer.
package lna_tr_sequencer_pkg;

   localparam int unsigned STATE_W               = 3;
   localparam int unsigned DEF_GUARD_CYCLES      = 4;
   localparam int unsigned DEF_RX_SETTLE_CYCLES  = 16;
   localparam int unsigned DEF_TX_SETTLE_CYCLES  = 8;
   localparam int unsigned DEF_TX_MAX_CYCLES     = 4096;
   localparam int unsigned DEF_CNT_W             = 13;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_RX_SETTLE = 3'd1,
      ST_RX_ON     = 3'd2,
      ST_TX_SETTLE = 3'd3,
      ST_TX_ON     = 3'd4,
      ST_OFF_GUARD = 3'd5
   } state_e;

   typedef struct packed {
      logic busy;
      logic en_rx;
      logic en_tx;
      logic rdy_rx;
      logic rdy_tx;
   } outs_t;

   // Per-state output levels; guard and idle drive both enables and readies low.
   function automatic outs_t decode_outs(input state_e st);
      outs_t o;
      o      = '0;
      o.busy = (st != ST_IDLE);
      case (st)
         ST_RX_SETTLE: o.en_rx = 1'b1;
         ST_RX_ON: begin
            o.en_rx  = 1'b1;
            o.rdy_rx = 1'b1;
         end
         ST_TX_SETTLE: o.en_tx = 1'b1;
         ST_TX_ON: begin
            o.en_tx  = 1'b1;
            o.rdy_tx = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/lna_tr_sequencer_timer.sv
// Loadable down-counter that holds at zero; zero_c marks the last cycle of a timed state.
module lna_guard_timer #(
   parameter int unsigned CNT_W = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/lna_tr_sequencer.sv
// LNA T/R sequencer: break-before-make enable sequencing with settle timing,
// per-path readiness and a sticky TX-on watchdog.
module lna_tr_sequencer
   import lna_tr_sequencer_pkg::*;
#(
   parameter int unsigned GUARD_CYCLES     = DEF_GUARD_CYCLES,
   parameter int unsigned RX_SETTLE_CYCLES = DEF_RX_SETTLE_CYCLES,
   parameter int unsigned TX_SETTLE_CYCLES = DEF_TX_SETTLE_CYCLES,
   parameter int unsigned TX_MAX_CYCLES    = DEF_TX_MAX_CYCLES,
   parameter int unsigned CNT_W            = DEF_CNT_W
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               RequestReceive,
   input  logic               RequestTransmit,
   input  logic               ClearFault,
   output logic               EnableReceive,
   output logic               EnableTransmit,
   output logic               ReceiveReady,
   output logic               TransmitReady,
   output logic               Busy,
   output logic               TxTimeout,
   output logic [STATE_W-1:0] State
);

   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   if (GUARD_CYCLES < 1 || RX_SETTLE_CYCLES < 1 || TX_SETTLE_CYCLES < 1 || TX_MAX_CYCLES < 1 ||
       64'(GUARD_CYCLES) > CNT_MAX || 64'(RX_SETTLE_CYCLES) > CNT_MAX ||
       64'(TX_SETTLE_CYCLES) > CNT_MAX || 64'(TX_MAX_CYCLES) > CNT_MAX) begin : g_param_check
      $error("lna_tr_sequencer: cycle parameter is zero or does not fit in CNT_W");
   end

   state_e           state_q;
   state_e           state_d;
   outs_t            outs_q;
   logic             timeout_q;
   logic             timeout_d;
   logic             wdog_fire_c;
   logic             tx_req_c;
   logic             tmr_load_c;
   logic [CNT_W-1:0] tmr_val_c;
   logic             tmr_zero_c;

   // A latched fault masks transmit requests until cleared.
   assign tx_req_c = RequestTransmit & ~timeout_q;

   always_comb begin
      state_d     = state_q;
      wdog_fire_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_req_c) begin
               state_d = ST_TX_SETTLE;
            end else if (RequestReceive) begin
               state_d = ST_RX_SETTLE;
            end
         end
         ST_RX_SETTLE: begin
            if (tx_req_c || !RequestReceive) begin
               state_d = ST_OFF_GUARD;
            end else if (tmr_zero_c) begin
               state_d = ST_RX_ON;
            end
         end
         ST_RX_ON: begin
            if (tx_req_c || !RequestReceive) begin
               state_d = ST_OFF_GUARD;
            end
         end
         ST_TX_SETTLE: begin
            if (!tx_req_c) begin
               state_d = ST_OFF_GUARD;
            end else if (tmr_zero_c) begin
               state_d = ST_TX_ON;
            end
         end
         ST_TX_ON: begin
            if (!tx_req_c) begin
               state_d = ST_OFF_GUARD;
            end else if (tmr_zero_c) begin
               state_d     = ST_OFF_GUARD;
               wdog_fire_c = 1'b1;
            end
         end
         ST_OFF_GUARD: begin
            if (tmr_zero_c) begin
               if (tx_req_c) begin
                  state_d = ST_TX_SETTLE;
               end else if (RequestReceive) begin
                  state_d = ST_RX_SETTLE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Fault flag: watchdog expiry beats a coincident clear.
   always_comb begin
      timeout_d = timeout_q;
      if (wdog_fire_c) begin
         timeout_d = 1'b1;
      end else if (ClearFault) begin
         timeout_d = 1'b0;
      end
   end

   // Reload the timer with N-1 whenever a state is entered.
   always_comb begin
      tmr_load_c = (state_d != state_q);
      tmr_val_c  = '0;
      case (state_d)
         ST_RX_SETTLE: tmr_val_c = CNT_W'(RX_SETTLE_CYCLES - 1);
         ST_TX_SETTLE: tmr_val_c = CNT_W'(TX_SETTLE_CYCLES - 1);
         ST_TX_ON:     tmr_val_c = CNT_W'(TX_MAX_CYCLES - 1);
         ST_OFF_GUARD: tmr_val_c = CNT_W'(GUARD_CYCLES - 1);
         default:      tmr_val_c = '0;
      endcase
   end

   lna_guard_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (Clock),
      .rst    (Reset),
      .load   (tmr_load_c),
      .value  (tmr_val_c),
      .zero_c (tmr_zero_c)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         outs_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         outs_q    <= decode_outs(state_d);
         timeout_q <= timeout_d;
      end
   end

   assign EnableReceive  = outs_q.en_rx;
   assign EnableTransmit = outs_q.en_tx;
   assign ReceiveReady   = outs_q.rdy_rx;
   assign TransmitReady  = outs_q.rdy_tx;
   assign Busy           = outs_q.busy;
   assign TxTimeout      = timeout_q;
   assign State          = state_q;

endmodule

// File: tb/tb_lna_tr_sequencer.sv
// Scoreboard bench for lna_tr_sequencer: a path/age reference model predicts every cycle's outputs.
module tb_lna_tr_sequencer;

   localparam int unsigned GUARD = 4;
   localparam int unsigned RXS   = 16;
   localparam int unsigned TXS   = 8;
   localparam int unsigned TXMAX = 4096;
   localparam int unsigned CW    = 13;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       RequestReceive;
   logic       RequestTransmit;
   logic       ClearFault;
   logic       EnableReceive;
   logic       EnableTransmit;
   logic       ReceiveReady;
   logic       TransmitReady;
   logic       Busy;
   logic       TxTimeout;
   logic [2:0] State;

   lna_tr_sequencer #(
      .GUARD_CYCLES     (GUARD),
      .RX_SETTLE_CYCLES (RXS),
      .TX_SETTLE_CYCLES (TXS),
      .TX_MAX_CYCLES    (TXMAX),
      .CNT_W            (CW)
   ) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .RequestReceive  (RequestReceive),
      .RequestTransmit (RequestTransmit),
      .ClearFault      (ClearFault),
      .EnableReceive   (EnableReceive),
      .EnableTransmit  (EnableTransmit),
      .ReceiveReady    (ReceiveReady),
      .TransmitReady   (TransmitReady),
      .Busy            (Busy),
      .TxTimeout       (TxTimeout),
      .State           (State)
   );

   always #5 Clock = ~Clock;

   int unsigned cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      int unsigned due;
      logic [8:0]  bits;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: which path is powered, how long it has been on, and guard progress.
   int unsigned m_path;   // 0 none, 1 receive, 2 transmit
   int unsigned m_age;    // cycles the current enable has been high, 1 on its first cycle
   int unsigned m_gap;    // cycles spent in the current guard gap
   bit          m_guard;
   bit          m_fault;

   // Monitor bookkeeping for independent invariant checks.
   int unsigned prev_path, low_run, tx_run, last_tx_run;
   bit          had_en;

   function automatic logic [8:0] outs();
      return {EnableReceive, EnableTransmit, ReceiveReady, TransmitReady, Busy, TxTimeout, State};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic model_reset();
      m_path  = 0;
      m_age   = 0;
      m_gap   = 0;
      m_guard = 1'b0;
      m_fault = 1'b0;
   endtask

   task automatic enter_guard();
      m_path  = 0;
      m_age   = 0;
      m_guard = 1'b1;
      m_gap   = 1;
   endtask

   task automatic model_step(input bit rr, input bit rt, input bit cf);
      bit txr;
      bit fire;
      txr  = rt && !m_fault;
      fire = 1'b0;
      if (m_path == 1) begin
         if (txr || !rr) enter_guard();
         else m_age++;
      end else if (m_path == 2) begin
         if (!txr) begin
            enter_guard();
         end else if (m_age == TXS + TXMAX) begin
            fire = 1'b1;
            enter_guard();
         end else begin
            m_age++;
         end
      end else if (m_guard && m_gap < GUARD) begin
         m_gap++;
      end else begin
         m_guard = 1'b0;
         m_gap   = 0;
         if (txr) begin
            m_path = 2;
            m_age  = 1;
         end else if (rr) begin
            m_path = 1;
            m_age  = 1;
         end
      end
      if (fire) m_fault = 1'b1;
      else if (cf) m_fault = 1'b0;
   endtask

   function automatic logic [8:0] model_expect();
      logic       er, et, rdr, rdt, busy;
      logic [2:0] st;
      er   = (m_path == 1);
      et   = (m_path == 2);
      rdr  = er && (m_age > RXS);
      rdt  = et && (m_age > TXS);
      busy = (m_path != 0) || m_guard;
      if (m_guard)  st = 3'd5;
      else if (er)  st = rdr ? 3'd2 : 3'd1;
      else if (et)  st = rdt ? 3'd4 : 3'd3;
      else          st = 3'd0;
      return {er, et, rdr, rdt, busy, m_fault, st};
   endfunction

   // Drive one cycle of inputs and queue what the DUT must show after the next edge.
   task automatic step(input bit rr, input bit rt, input bit cf);
      @(posedge Clock);
      #1;
      RequestReceive  = rr;
      RequestTransmit = rt;
      ClearFault      = cf;
      model_step(rr, rt, cf);
      exp_q.push_back('{due: cyc + 1, bits: model_expect()});
   endtask

   task automatic hold(input bit rr, input bit rt, input int unsigned n);
      repeat (n) step(rr, rt, 1'b0);
   endtask

   task automatic monitor();
      exp_t        e;
      int unsigned cur;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            had_en    = 1'b0;
            prev_path = 0;
            low_run   = 0;
            tx_run    = 0;
         end else begin
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               e = exp_q.pop_front();
               check("outputs", 32'(outs()), 32'(e.bits));
            end
            check("both_enables", 32'(EnableReceive & EnableTransmit), 32'd0);
            cur = EnableReceive ? 1 : (EnableTransmit ? 2 : 0);
            if (cur != 0) begin
               if (prev_path == 0 && had_en) check("guard_gap_ok", 32'(low_run >= GUARD), 32'd1);
               if (prev_path != 0) check("path_swap_without_gap", prev_path, cur);
               had_en  = 1'b1;
               low_run = 0;
            end else begin
               low_run++;
            end
            prev_path = cur;
            if (TransmitReady) begin
               tx_run++;
            end else if (tx_run != 0) begin
               last_tx_run = tx_run;
               tx_run      = 0;
            end
         end
      end
   endtask

   initial begin
      bit          rr, rt;
      int unsigned len;
      Reset           = 1'b1;
      RequestReceive  = 1'b0;
      RequestTransmit = 1'b0;
      ClearFault      = 1'b0;
      last_tx_run     = 0;
      model_reset();
      fork
         monitor();
      join_none

      repeat (3) @(posedge Clock);
      #1;
      check("reset_outputs", 32'(outs()), 32'd0);
      @(negedge Clock) Reset = 1'b0;

      // Receive bring-up, then release.
      hold(1, 0, RXS + 6);
      hold(0, 0, GUARD + 3);

      // Receive on, then transmit takes over.
      hold(1, 0, RXS + 4);
      hold(1, 1, GUARD + TXS + 6);
      hold(0, 0, GUARD + 3);

      // Watchdog with the request held; then clear and retry.
      hold(0, 1, TXS + TXMAX + 20);
      check("tx_timeout_set", 32'(TxTimeout), 32'd1);
      check("tx_off_after_timeout", 32'(EnableTransmit), 32'd0);
      check("tx_ready_run_len", last_tx_run, TXMAX);
      step(0, 1, 1);
      hold(0, 1, TXS + 6);
      hold(0, 0, GUARD + 3);

      // Watchdog expiry coinciding with a held clear: expiry must win for a cycle.
      repeat (TXS + TXMAX + 12) step(0, 1, 1);
      hold(0, 0, GUARD + 3);

      // Both requests from idle, then transmit released with receive still wanted.
      hold(1, 1, TXS + 6);
      hold(1, 0, GUARD + RXS + 6);
      hold(0, 0, GUARD + 3);

      // One-cycle glitches during settle.
      hold(1, 0, 3);
      hold(0, 0, 1);
      hold(1, 0, 3);
      step(1, 1, 0);
      hold(1, 0, GUARD + RXS + 3);
      hold(0, 0, GUARD + 3);

      // Asynchronous reset in the middle of TX_ON.
      hold(0, 1, TXS + 10);
      @(posedge Clock);
      #3;
      Reset           = 1'b1;
      RequestTransmit = 1'b0;
      RequestReceive  = 1'b0;
      #1;
      check("async_reset_outputs", 32'(outs()), 32'd0);
      exp_q.delete();
      model_reset();
      repeat (2) @(posedge Clock);
      @(negedge Clock) Reset = 1'b0;
      @(negedge Clock);
      #1;
      check("idle_after_reset", 32'(outs()), 32'd0);

      // Randomized request toggling.
      for (int s = 0; s < 600; s++) begin
         rr  = 1'($urandom_range(0, 1));
         rt  = ($urandom_range(0, 2) == 0);
         len = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 60);
         for (int i = 0; i < int'(len); i++) step(rr, rt, ($urandom_range(0, 30) == 0));
      end

      hold(0, 0, GUARD + 4);
      repeat (2) @(posedge Clock);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
